// File: rtl/lcd_pixel_shader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_video_pkg
//  Purpose  : Shared types, defaults and helpers for the LCD pixel shader.
//             The pixel colour type, the frame geometry and colour defaults,
//             and the per-channel darkening function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lcd_video_pkg;

  // One 24-bit pixel, red in the top byte.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_WIDTH  = 360;
  localparam int DEF_HEIGHT = 360;
  localparam int BG_PIXELS  = DEF_WIDTH * DEF_HEIGHT;

  localparam logic [23:0] DEF_ON_COLOR  = 24'h202020;
  localparam logic [23:0] DEF_OFF_COLOR = 24'hB0C0A0;

  // Each channel is shifted on its own with zero fill, so no bit of one
  // channel ever leaks into its neighbour.
  function automatic rgb_t darken(input rgb_t c, input int unsigned sh);
    rgb_t res;
    res.r = c.r >> sh;
    res.g = c.g >> sh;
    res.b = c.b >> sh;
    return res;
  endfunction

endpackage : lcd_video_pkg
`default_nettype wire

// File: rtl/lcd_pixel_shader_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pixel_shader_if
//  Purpose  : Bundles the generator timing stream, the VRAM and background
//             ROM read ports and the RGB output stream of the pixel shader.
//  Ports    : master - upstream/memory/sink side (drives generator signals
//                      and memory read data, receives addresses and video)
//             slave  - the pixel shader itself
//  Revision : 1.0  initial release
// ============================================================================
interface lcd_pixel_shader_if
  import lcd_video_pkg::*;
#(
  parameter int BG_ADDR_W = 17
);

  // Generator stream
  logic [7:0]           video_addr;
  logic [1:0]           lcd_segment_row;
  logic                 de_in;
  logic                 hsync_in;
  logic                 vsync_in;
  logic                 show_bg;

  // Memory read ports
  logic [7:0]           vram_addr;
  logic [3:0]           vram_q;
  logic [BG_ADDR_W-1:0] bg_addr;
  rgb_t                 bg_q;

  // Output video stream
  rgb_t                 rgb;
  logic                 de;
  logic                 hsync;
  logic                 vsync;

  modport master (
    output video_addr, lcd_segment_row, de_in, hsync_in, vsync_in, show_bg,
    output vram_q, bg_q,
    input  vram_addr, bg_addr,
    input  rgb, de, hsync, vsync
  );

  modport slave (
    input  video_addr, lcd_segment_row, de_in, hsync_in, vsync_in, show_bg,
    input  vram_q, bg_q,
    output vram_addr, bg_addr,
    output rgb, de, hsync, vsync
  );

endinterface : lcd_pixel_shader_if
`default_nettype wire

// File: rtl/lcd_pixel_shader_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module   : video_sync_delay
//  Purpose  : N-stage register delay for a W-bit bundle of video sync bits,
//             packed {de, hsync, vsync}. Also exposes the MSB of the stage
//             feeding the last register so the caller can gate the last
//             pipeline stage with the data enable one cycle early.
//  Ports    : clk      - pixel clock
//             rst_n    - async-assert / sync-release active-low reset
//             sync_i   - bundle entering the delay line
//             lead_o   - MSB of the bundle one stage before the output
//             sync_o   - bundle delayed by N cycles
//  Revision : 1.0  initial release
// ============================================================================
module video_sync_delay #(
  parameter int N = 2,
  parameter int W = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [W-1:0] sync_i,
  output      logic         lead_o,
  output      logic [W-1:0] sync_o
);

  logic [N-1:0][W-1:0] stage_q;
  logic [N-1:0][W-1:0] stage_d;

  // Shift chain: stage 0 loads the input, every later stage its predecessor.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = sync_i;
    for (int i = 1; i < N; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_o = stage_q[N-1];

  // With a single stage the "one before the output" point is the input.
  if (N >= 2) begin : g_lead_stage
    assign lead_o = stage_q[N-2][W-1];
  end else begin : g_lead_input
    assign lead_o = sync_i[W-1];
  end

endmodule : video_sync_delay
`default_nettype wire

// File: rtl/lcd_pixel_shader.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pixel_shader
//  Purpose  : Turns the LCD generator's timing/VRAM address stream into a
//             24-bit RGB stream. Each pixel picks one segment bit out of the
//             addressed VRAM nibble; lit segments are drawn either in a flat
//             ON colour or as a darkened copy of a background image, unlit
//             ones in a flat OFF colour or the plain background. Sync and
//             data enable are delayed to stay aligned with the pixel data.
//  Ports    : clk      - pixel clock
//             reset_n  - asynchronous active-low reset
//             bus      - slave side of lcd_pixel_shader_if:
//                        video_addr/lcd_segment_row/de_in/hsync_in/vsync_in/
//                        show_bg in, vram_addr/vram_q VRAM port,
//                        bg_addr/bg_q background ROM port,
//                        rgb/de/hsync/vsync out (2-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module lcd_pixel_shader
  import lcd_video_pkg::*;
#(
  parameter int          WIDTH        = DEF_WIDTH,
  parameter int          HEIGHT       = DEF_HEIGHT,
  parameter int          BG_ADDR_W    = 17,
  parameter int          DARKEN_SHIFT = 2,
  parameter logic [23:0] ON_COLOR     = DEF_ON_COLOR,
  parameter logic [23:0] OFF_COLOR    = DEF_OFF_COLOR
) (
  input wire logic          clk,
  input wire logic          reset_n,
  lcd_pixel_shader_if.slave bus
);

  localparam int                   PIXELS   = WIDTH * HEIGHT;
  localparam logic [BG_ADDR_W-1:0] LAST_PIX = BG_ADDR_W'(PIXELS - 1);
  localparam int                   PIPE_N   = 2;

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop immediately, release is
  // retimed to clk so no flop sees a deassertion near its clock edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // VRAM address is a straight pass-through; the RAM's own read register
  // provides the first pipeline stage for the nibble.
  // --------------------------------------------------------------------------
  assign bus.vram_addr = bus.video_addr;

  // --------------------------------------------------------------------------
  // Background pixel counter. vsync wins over de so a pixel coincident with
  // vsync starts the new frame at address 0 without advancing it.
  // --------------------------------------------------------------------------
  logic [BG_ADDR_W-1:0] pix_cnt_q;
  logic [BG_ADDR_W-1:0] pix_cnt_d;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (bus.vsync_in) begin
      pix_cnt_d = '0;
    end else if (bus.de_in) begin
      pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 1'b1;
    end
  end

  assign bus.bg_addr = pix_cnt_q;

  // --------------------------------------------------------------------------
  // Background enable is only sampled during vsync so one frame never mixes
  // the two colour schemes.
  // --------------------------------------------------------------------------
  logic bg_en_q;
  logic bg_en_d;

  always_comb begin
    bg_en_d = bg_en_q;
    if (bus.vsync_in) begin
      bg_en_d = bus.show_bg;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      pix_cnt_q <= '0;
      bg_en_q   <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      bg_en_q   <= bg_en_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: the segment row select is delayed to meet the VRAM read data.
  // --------------------------------------------------------------------------
  logic [1:0] row_d1_q;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      row_d1_q <= 2'b00;
    end else begin
      row_d1_q <= bus.lcd_segment_row;
    end
  end

  // Sync bundle delay: {de, hsync, vsync}; de_d1 is the stage-1 data enable.
  logic       de_d1;
  logic [2:0] sync_d2;

  video_sync_delay #(
    .N (PIPE_N),
    .W (3)
  ) u_sync_delay (
    .clk    (clk),
    .rst_n  (rst_n_sync),
    .sync_i ({bus.de_in, bus.hsync_in, bus.vsync_in}),
    .lead_o (de_d1),
    .sync_o (sync_d2)
  );

  // --------------------------------------------------------------------------
  // Colour selection, combinational on the stage-1 data.
  // --------------------------------------------------------------------------
  logic lit;
  rgb_t color;

  assign lit = bus.vram_q[row_d1_q];

  always_comb begin
    color = rgb_t'(OFF_COLOR);
    if (bg_en_q) begin
      color = lit ? darken(bus.bg_q, DARKEN_SHIFT) : bus.bg_q;
    end else begin
      color = lit ? rgb_t'(ON_COLOR) : rgb_t'(OFF_COLOR);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: registered outputs. Blanking pixels are forced to black so the
  // scaler never sees stale colour outside the active area.
  // --------------------------------------------------------------------------
  rgb_t rgb_q;
  rgb_t rgb_d;

  always_comb begin
    rgb_d = '0;
    if (de_d1) begin
      rgb_d = color;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign bus.rgb   = rgb_q;
  assign bus.de    = sync_d2[2];
  assign bus.hsync = sync_d2[1];
  assign bus.vsync = sync_d2[0];

endmodule : lcd_pixel_shader
`default_nettype wire
